// File: rtl/bus_transfer_sequencer_if.sv
// Command handshake and register-file strobe bundle for the bus transfer sequencer.
// The master side issues transfer commands; the slave side (the sequencer)
// drives the per-register enable/set strobes and the external bus value.
interface bus_transfer_sequencer_if #(
   parameter int SELW = 2
);
   localparam int NREG = 2**SELW;

   logic            cmd_valid;
   logic            cmd_ready;
   logic [SELW-1:0] cmd_src;
   logic [SELW-1:0] cmd_dst;
   logic            cmd_ext;
   logic [7:0]      cmd_data;
   logic [NREG-1:0] reg_en;
   logic [NREG-1:0] reg_set;
   logic            ext_en;
   logic [7:0]      ext_data;
   logic            done;
   logic            busy;

   modport master (
      output cmd_valid, cmd_src, cmd_dst, cmd_ext, cmd_data,
      input  cmd_ready, reg_en, reg_set, ext_en, ext_data, done, busy
   );

   modport slave (
      input  cmd_valid, cmd_src, cmd_dst, cmd_ext, cmd_data,
      output cmd_ready, reg_en, reg_set, ext_en, ext_data, done, busy
   );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Bus transfer sequencer: queues up to two commands and steps each through
// DRIVE -> LATCH -> HOLD so the NAND-latch registers see the bus settle before
// set rises and stay driven while set falls. All strobes leave from flops.
module bus_transfer_sequencer #(
   parameter int SELW = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   bus_transfer_sequencer_if.slave bus
);
   localparam int NREG = 2**SELW;

   typedef enum logic [1:0] {IDLE, DRIVE, LATCH, HOLD} state_t;

   typedef struct packed {
      logic [SELW-1:0] src;
      logic [SELW-1:0] dst;
      logic            ext;
      logic [7:0]      data;
   } cmd_t;

   state_t          state_q, state_d;
   logic [1:0]      count_q, count_d;
   cmd_t            q_q [2];
   cmd_t            q_d [2];
   cmd_t            cur_q, cur_d;
   cmd_t            in_cmd;
   logic [NREG-1:0] reg_en_q, reg_en_d;
   logic [NREG-1:0] reg_set_q, reg_set_d;
   logic            ext_en_q, ext_en_d;
   logic [7:0]      ext_data_q, ext_data_d;
   logic            done_q, done_d;
   logic            accept, start, pop, bypass, push;
   logic [1:0]      count_pop;

   function automatic logic [NREG-1:0] onehot(input logic [SELW-1:0] idx);
      logic [NREG-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // cmd_ready looks at the pre-pop count, so a full queue refuses even on a pop edge
   assign bus.cmd_ready = (count_q < 2'd2) & rst_n;
   assign accept        = bus.cmd_valid & bus.cmd_ready;
   assign in_cmd        = {bus.cmd_src, bus.cmd_dst, bus.cmd_ext, bus.cmd_data};

   assign bus.reg_en   = reg_en_q;
   assign bus.reg_set  = reg_set_q;
   assign bus.ext_en   = ext_en_q;
   assign bus.ext_data = ext_data_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state_q != IDLE) | (count_q != 2'd0);

   // Queue bookkeeping: pick the next command (queue head or bypass) and update the FIFO
   always_comb begin
      start     = ((state_q == IDLE) || (state_q == HOLD)) && ((count_q != 2'd0) || accept);
      pop       = start && (count_q != 2'd0);
      bypass    = start && (count_q == 2'd0);
      push      = accept && !bypass;
      count_pop = pop ? (count_q - 2'd1) : count_q;
      count_d   = push ? (count_pop + 2'd1) : count_pop;
      q_d[0]    = q_q[0];
      q_d[1]    = q_q[1];
      if (pop) begin
         q_d[0] = q_q[1];
      end
      if (push) begin
         if (count_pop == 2'd0) begin
            q_d[0] = in_cmd;
         end else begin
            q_d[1] = in_cmd;
         end
      end
      cur_d = cur_q;
      if (pop) begin
         cur_d = q_q[0];
      end else if (bypass) begin
         cur_d = in_cmd;
      end
   end

   // Transfer FSM next state: HOLD chains straight into the next DRIVE when work is pending
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = DRIVE;
         DRIVE:   state_d = LATCH;
         LATCH:   state_d = HOLD;
         HOLD:    state_d = start ? DRIVE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobe values for the coming cycle, derived from next state and next command
   always_comb begin
      reg_en_d   = '0;
      reg_set_d  = '0;
      ext_en_d   = 1'b0;
      ext_data_d = 8'h00;
      done_d     = 1'b0;
      if (state_d != IDLE) begin
         if (cur_d.ext) begin
            ext_en_d   = 1'b1;
            ext_data_d = cur_d.data;
         end else begin
            reg_en_d = onehot(cur_d.src);
         end
         // a register copied onto itself is a no-op, so its set strobe is withheld
         if ((state_d == LATCH) && (cur_d.ext || (cur_d.src != cur_d.dst))) begin
            reg_set_d = onehot(cur_d.dst);
         end
         done_d = (state_d == HOLD);
      end
   end

   // Control state and output strobes; reset discards in-flight and queued work
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         count_q    <= 2'd0;
         reg_en_q   <= '0;
         reg_set_q  <= '0;
         ext_en_q   <= 1'b0;
         ext_data_q <= 8'h00;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         reg_en_q   <= reg_en_d;
         reg_set_q  <= reg_set_d;
         ext_en_q   <= ext_en_d;
         ext_data_q <= ext_data_d;
         done_q     <= done_d;
      end
   end

   // Command payload storage; contents are only meaningful when count/state say so
   always_ff @(posedge clk) begin
      q_q[0] <= q_d[0];
      q_q[1] <= q_d[1];
      cur_q  <= cur_d;
   end
endmodule

// File: doc/bus_transfer_sequencer.md
# bus_transfer_sequencer

Sequences register-to-register and external-to-register transfers over the shared 8-bit bus of the mini computer datapath. It generates the per-register enable and set strobes in the order the NAND-latch registers need: drive the bus, pulse set, then hold the bus while set falls. Commands arrive on a valid/ready interface into a 2-entry queue, so the block sits between instruction control and the register file.

## Interface
Parameters:
- SELW, 2, width of register select; NREG = 2**SELW registers driven

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  queue can accept; a command is accepted on an edge where cmd_valid & cmd_ready
- cmd_src  in  SELW  source register index; ignored when cmd_ext=1
- cmd_dst  in  SELW  destination register index
- cmd_ext  in  1  1 = source is cmd_data driven by this block, not a register
- cmd_data  in  8  external value, captured at acceptance
- reg_en  out  NREG  one-hot register output enable (bus driver)
- reg_set  out  NREG  one-hot register set strobe
- ext_en  out  1  external driver enable onto bus
- ext_data  out  8  external value; 0 when ext_en=0
- done  out  1  one-cycle pulse per completed transfer
- busy  out  1  state != IDLE or queue non-empty

## Operation
- Queue: 2-entry FIFO of {src,dst,ext,data}; cmd_ready = (count<2) & rst_n. Write on accept; pop when FSM leaves IDLE or HOLD to start a command.
- If FSM is idle and queue empty, an accepted command bypasses the queue and starts at the same edge.
- FSM states: IDLE, DRIVE, LATCH, HOLD.
  - IDLE: all strobes 0. Command available -> DRIVE.
  - DRIVE: source enable high (reg_en[src] or ext_en), set low. -> LATCH.
  - LATCH: source enable high, reg_set[dst] high. -> HOLD.
  - HOLD: source enable high, set low, done=1. Next command available -> DRIVE directly; else -> IDLE.
- At most one bit of reg_en|ext_en is high; at most one bit of reg_set is high; reg_set is high only in LATCH.
- src==dst with cmd_ext=0: full sequence runs, reg_set suppressed (self-transfer is a no-op), done still pulses.
- All outputs registered; no combinational path from cmd_* to reg_en/reg_set/ext_en.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, queue empty, reg_en=0, reg_set=0, ext_en=0, ext_data=0, done=0, busy=0, cmd_ready=0 while rst_n=0.
- Reset mid-transfer: strobes drop at that edge; the in-flight command and queued commands are discarded; no done pulse.
- Latency: command accepted at edge E0 while idle -> DRIVE during cycle after E0, LATCH after E1, HOLD with done after E2.
- Throughput: back-to-back commands take 3 cycles each, no IDLE gap; source enable may switch between HOLD and the next DRIVE.
- Simultaneous accept and pop in HOLD with queue full: pop frees the slot, but cmd_ready uses pre-pop count, so accept is refused that cycle.
- cmd_ready=0 when 2 commands are queued, even while one executes (1 executing + 2 queued max).

## Test plan
- Reset: hold rst_n=0 for 2 cycles with cmd_valid=1 -> all outputs 0, cmd_ready=0, no command accepted; release -> cmd_ready=1.
- Single reg transfer src=1,dst=3: -> reg_en=0010 for 3 cycles, reg_set=1000 only in 2nd cycle, done in 3rd, then IDLE with busy=0.
- External load cmd_ext=1, data=8'hA5, dst=2 -> ext_en=1 and ext_data=A5 for 3 cycles, reg_set=0100 in middle cycle, reg_en=0 throughout.
- Push 4 commands back-to-back with cmd_valid held -> cmd_ready drops after 3rd acceptance; 4 done pulses spaced exactly 3 cycles; strobe order matches issue order.
- Self-transfer src=dst=0 -> reg_en=0001 for 3 cycles, reg_set stays 0, done pulses once.
- rst_n=0 during LATCH with 2 queued -> next cycle all strobes 0, busy=0, no further done pulses after release.
